idx_to_ascii_conv: RTL and testbench

//  Converts a packed candidate-password vector of NUM_CHARS charset indices into an ASCII string.

---
 rtl/idx_ascii_pkg.sv | 19 +
 rtl/idx_ascii_lut.sv | 33 +++
 rtl/idx_to_ascii_conv.sv | 93 +++++++++
 tb/tb_idx_to_ascii_conv.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/idx_ascii_pkg.sv
// Shared types and constants for the charset-index to ASCII converter.
// The lookup honours the CHARSET_EXT_EN macro (see idx_ascii_lut).
package idx_ascii_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CONV,
      HOLD
   } state_t;

   localparam logic [7:0] ASCII_LC_A = 8'h61;
   localparam logic [7:0] ASCII_UC_A = 8'h41;
   localparam logic [7:0] ASCII_0    = 8'h30;
   localparam logic [7:0] ASCII_INV  = 8'h3F;

   localparam int CS_LC  = 26;
   localparam int CS_EXT = 62;

endpackage

// File: rtl/idx_ascii_lut.sv
// Combinational charset lookup: one index in, one ASCII char plus invalid flag out.
// CHARSET_EXT_EN selects the 62-symbol alphanumeric set; default is lowercase only.
module idx_ascii_lut
   import idx_ascii_pkg::*;
#(
   parameter int IDX_W = 6
) (
   input  logic [IDX_W-1:0] i_idx,
   output logic [7:0]       o_char,
   output logic             o_inv
);

   // Offsets stay below 26, so the 8-bit sums never wrap
   always_comb begin
      o_char = ASCII_INV;
      o_inv  = 1'b1;
      if (i_idx < IDX_W'(CS_LC)) begin
         o_char = ASCII_LC_A + 8'(i_idx);
         o_inv  = 1'b0;
      end
`ifdef CHARSET_EXT_EN
      else if (i_idx < IDX_W'(2 * CS_LC)) begin
         o_char = ASCII_UC_A + 8'(i_idx - IDX_W'(CS_LC));
         o_inv  = 1'b0;
      end
      else if (i_idx < IDX_W'(CS_EXT)) begin
         o_char = ASCII_0 + 8'(i_idx - IDX_W'(2 * CS_LC));
         o_inv  = 1'b0;
      end
`endif
   end

endmodule

// File: rtl/idx_to_ascii_conv.sv
// Converts a packed vector of charset indices into an ASCII string, one char per clock.
// Charset width follows CHARSET_EXT_EN via the shared lookup.
module idx_to_ascii_conv
   import idx_ascii_pkg::*;
#(
   parameter int NUM_CHARS = 4,
   parameter int IDX_W     = 6
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [NUM_CHARS*IDX_W-1:0] in_idx,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [NUM_CHARS*8-1:0]     out_str,
   output logic                       out_err
);

   localparam int CNT_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;

   state_t                     r_state;
   logic [NUM_CHARS*IDX_W-1:0] r_idx;
   logic [CNT_W-1:0]           r_cnt;
   logic                       r_in_ready;
   logic                       r_out_valid;
   logic [NUM_CHARS*8-1:0]     r_str;
   logic                       r_err;

   logic [IDX_W-1:0]           w_idx;
   logic [7:0]                 w_char;
   logic                       w_inv;

   assign w_idx = r_idx[r_cnt*IDX_W +: IDX_W];

   idx_ascii_lut #(
      .IDX_W (IDX_W)
   ) u_lut (
      .i_idx  (w_idx),
      .o_char (w_char),
      .o_inv  (w_inv)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_cnt       <= '0;
         r_in_ready  <= 1'b1;
         r_out_valid <= 1'b0;
         r_str       <= '0;
         r_err       <= 1'b0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (in_valid && r_in_ready) begin
                  r_idx      <= in_idx;
                  r_str      <= '0;
                  r_err      <= 1'b0;
                  r_cnt      <= '0;
                  r_in_ready <= 1'b0;
                  r_state    <= CONV;
               end
            end
            CONV: begin
               r_str[r_cnt*8 +: 8] <= w_char;
               r_err               <= r_err | w_inv;
               if (r_cnt == CNT_W'(NUM_CHARS - 1)) begin
                  r_out_valid <= 1'b1;
                  r_state     <= HOLD;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            HOLD: begin
               // String stays frozen until the consumer takes it
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign out_str   = r_str;
   assign out_err   = r_err;

endmodule

// File: tb/tb_idx_to_ascii_conv.sv
// Directed plus randomized bench for idx_to_ascii_conv against a charset reference model.
// Expected chars come from arithmetic on the charset ranges; CHARSET_EXT_EN mirrors the build.
module tb_idx_to_ascii_conv;

   localparam int N = 4;
   localparam int W = 6;

   logic           clk = 1'b0;
   logic           rst;
   logic           in_valid;
   logic           in_ready;
   logic [N*W-1:0] in_idx;
   logic           out_valid;
   logic           out_ready;
   logic [N*8-1:0] out_str;
   logic           out_err;

   int vecs = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   idx_to_ascii_conv #(
      .NUM_CHARS (N),
      .IDX_W     (W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_idx    (in_idx),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_str   (out_str),
      .out_err   (out_err)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ref_char(input int v, output bit bad);
      bad = 1'b0;
      if (v < 26) return 8'(97 + v);
`ifdef CHARSET_EXT_EN
      if (v < 52) return 8'(65 + v - 26);
      if (v < 62) return 8'(48 + v - 52);
`endif
      bad = 1'b1;
      return 8'h3F;
   endfunction

   function automatic void ref_model(input logic [N*W-1:0] v,
                                     output logic [N*8-1:0] s,
                                     output logic e);
      bit b;
      s = '0;
      e = 1'b0;
      for (int k = 0; k < N; k++) begin
         s[k*8 +: 8] = ref_char(int'(v[k*W +: W]), b);
         e = e | b;
      end
   endfunction

   function automatic logic [N*W-1:0] pack(input int a0, input int a1,
                                           input int a2, input int a3);
      logic [N*W-1:0] v;
      v = '0;
      v[0*W +: W] = W'(a0);
      v[1*W +: W] = W'(a1);
      v[2*W +: W] = W'(a2);
      v[3*W +: W] = W'(a3);
      return v;
   endfunction

   task automatic send(input logic [N*W-1:0] v, input int hold,
                       input string tag);
      logic [N*8-1:0] es;
      logic           ee;
      int             w;
      ref_model(v, es, ee);
      w = 0;
      while (!in_ready && w < 20) begin
         @(posedge clk); #1;
         w++;
      end
      check({tag, ".rdy"}, 64'(in_ready), 64'd1);
      out_ready = (hold == 0);
      in_valid  = 1'b1;
      in_idx    = v;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_idx   = N*W'($urandom);
      for (int i = 1; i <= N; i++) begin
         @(posedge clk); #1;
         if (i < N)
            check({tag, ".busy"}, 64'({out_valid, in_ready}), 64'd0);
      end
      check({tag, ".vld"}, 64'({out_valid, in_ready}), 64'b10);
      check({tag, ".str"}, 64'(out_str), 64'(es));
      check({tag, ".err"}, 64'(out_err), 64'(ee));
      for (int j = 0; j < hold; j++) begin
         in_valid = 1'($urandom);
         in_idx   = N*W'($urandom);
         @(posedge clk); #1;
         in_valid = 1'b0;
         check({tag, ".hold"},
               64'({out_valid, in_ready, out_err, out_str}),
               64'({1'b1, 1'b0, ee, es}));
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, ".idle"},
            64'({out_valid, in_ready, out_err, out_str}),
            64'({1'b0, 1'b1, ee, es}));
   endtask

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_idx    = '0;
      out_ready = 1'b0;

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk); #1;
      check("reset", 64'({in_ready, out_valid, out_err, out_str}),
            64'({1'b1, 1'b0, 1'b0, 32'h0}));

      send(pack(0, 1, 2, 3), 0, "basic");
      check("basic.abcd", 64'(out_str), 64'h64636261);

`ifdef CHARSET_EXT_EN
      send(pack(26, 51, 52, 61), 0, "ext");
      check("ext.const", 64'({out_err, out_str}), 64'({1'b0, 32'h39305A41}));
      send(pack(62, 0, 0, 0), 0, "ext_inv");
      check("ext_inv.const", 64'({out_err, out_str[7:0]}), 64'({1'b1, 8'h3F}));
`else
      send(pack(25, 26, 0, 25), 0, "bound");
      check("bound.const", 64'({out_err, out_str}), 64'({1'b1, 32'h7A613F7A}));
      send(pack(0, 0, 0, 0), 0, "zero");
      check("zero.err", 64'(out_err), 64'd0);
`endif

      send(pack(7, 30, 63, 12), 10, "bp");

      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_idx    = pack(4, 5, 6, 7);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      check("mid_rst", 64'({in_ready, out_valid, out_err, out_str}),
            64'({1'b1, 1'b0, 1'b0, 32'h0}));
      repeat (2) @(posedge clk);
      #1;
      check("mid_rst.hold", 64'({in_ready, out_valid}), 64'b10);
      rst = 1'b0;
      out_ready = 1'b0;
      send(pack(19, 4, 18, 19), 0, "post_rst");

      for (int t = 0; t < 16; t++) begin
         send(pack($urandom_range(0, 63), $urandom_range(0, 63),
                   $urandom_range(0, 63), $urandom_range(0, 63)),
              int'($urandom_range(0, 3)), $sformatf("rnd%0d", t));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
      $finish;
   end

endmodule
